// File: rtl/rvv_vector_issue_ctrl_pkg.sv
// Shared types for the scalar-side vector issue controller.
package rvv_defs;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RETIRE
    } issue_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] vl;
    } issue_entry_t;

endpackage

// File: rtl/rvv_vector_issue_ctrl_if.sv
// Handshake bundle: scalar request side, vector system side and result return side.
interface rvv_vector_issue_ctrl_if #(
    parameter int VLEN = 512
);
    logic            s_valid;
    logic            s_ready;
    logic [31:0]     s_instr;
    logic [31:0]     s_vl;
    logic [31:0]     v_instr;
    logic [31:0]     v_vl;
    logic            v_alu_rst;
    logic            v_ready;
    logic [VLEN-1:0] v_result;
    logic            r_valid;
    logic            r_ready;
    logic [VLEN-1:0] r_data;
    logic            r_err;

    // master is the issue controller, slave is everything around it
    modport master (
        input  s_valid, s_instr, s_vl, v_ready, v_result, r_ready,
        output s_ready, v_instr, v_vl, v_alu_rst, r_valid, r_data, r_err
    );

    modport slave (
        output s_valid, s_instr, s_vl, v_ready, v_result, r_ready,
        input  s_ready, v_instr, v_vl, v_alu_rst, r_valid, r_data, r_err
    );
endinterface

// File: rtl/rvv_vector_issue_ctrl_fifo.sv
// Instruction queue between the scalar pipeline and the issue FSM; head is read combinationally.
module rvv_issue_fifo
    import rvv_defs::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  issue_entry_t din,
    output issue_entry_t dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    localparam int CW = AW + 1;

    issue_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/rvv_vector_issue_ctrl.sv
// Issues queued vector ops one at a time, sequences the ALU reset, captures results and flags timeouts.
module rvv_vector_issue_ctrl
    import rvv_defs::*;
#(
    parameter int DEPTH   = 4,
    parameter int VLEN    = 512,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    rvv_vector_issue_ctrl_if.master  io,
    output logic                     busy,
    output logic [CNT_W-1:0]         retired
);
    localparam int AW = $clog2(DEPTH);

    issue_state_t    state;
    issue_entry_t    head;
    issue_entry_t    push_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     fifo_cnt;
    logic            pop;
    logic [CNT_W-1:0] tmo_cnt;
    logic [31:0]     v_instr_q;
    logic [31:0]     v_vl_q;
    logic            v_alu_rst_q;
    logic            r_valid_q;
    logic [VLEN-1:0] r_data_q;
    logic            r_err_q;

    assign push_entry = '{instr: io.s_instr, vl: io.s_vl};
    // single result register: only pop when the slot is empty or being drained now
    assign pop  = (state == IDLE) && !fifo_empty && (!r_valid_q || io.r_ready);
    assign busy = (state != IDLE) || (fifo_cnt != '0);

    assign io.s_ready   = !fifo_full;
    assign io.v_instr   = v_instr_q;
    assign io.v_vl      = v_vl_q;
    assign io.v_alu_rst = v_alu_rst_q;
    assign io.r_valid   = r_valid_q;
    assign io.r_data    = r_data_q;
    assign io.r_err     = r_err_q;

    rvv_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (io.s_valid),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            v_instr_q   <= '0;
            v_vl_q      <= '0;
            v_alu_rst_q <= 1'b0;
            tmo_cnt     <= '0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            r_err_q     <= 1'b0;
            retired     <= '0;
        end else begin
            if (r_valid_q && io.r_ready) r_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        v_instr_q <= head.instr;
                        v_vl_q    <= head.vl;
                        state     <= ISSUE;
                    end
                end
                // core still held in reset so the decoder can latch v_instr
                ISSUE: begin
                    tmo_cnt     <= '0;
                    v_alu_rst_q <= 1'b1;
                    state       <= WAIT;
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    if (io.v_ready) begin
                        r_data_q    <= io.v_result;
                        r_err_q     <= 1'b0;
                        r_valid_q   <= 1'b1;
                        v_alu_rst_q <= 1'b0;
                        state       <= RETIRE;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_data_q    <= '0;
                        r_err_q     <= 1'b1;
                        r_valid_q   <= 1'b1;
                        v_alu_rst_q <= 1'b0;
                        state       <= RETIRE;
                    end
                end
                RETIRE: begin
                    retired <= retired + CNT_W'(1);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rvv_vector_issue_ctrl.sv
// Directed scenarios plus a randomized run scored against a queue-based model of the issue controller.
module tb_rvv_vector_issue_ctrl;
    import rvv_defs::*;

    localparam int DEPTH   = 4;
    localparam int VLEN    = 512;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;
    localparam int N_RAND  = 40;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] retired;
    int               n_chk = 0;
    int               n_bad = 0;

    rvv_vector_issue_ctrl_if #(.VLEN(VLEN)) bus ();

    rvv_vector_issue_ctrl #(
        .DEPTH(DEPTH), .VLEN(VLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .io(bus), .busy(busy), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] ref_v);
        n_chk++;
        if (obs !== ref_v) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, ref_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VLEN-1:0] rnd_vec();
        logic [VLEN-1:0] v;
        for (int k = 0; k < VLEN / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.s_valid  = 1'b0;
        bus.s_instr  = '0;
        bus.s_vl     = '0;
        bus.v_ready  = 1'b0;
        bus.v_result = '0;
        bus.r_ready  = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] vl);
        bit ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_instr = ins;
        bus.s_vl    = vl;
        for (int k = 0; k < 100 && !ok; k++) begin
            ok = bus.s_ready;
            step();
        end
        bus.s_valid = 1'b0;
        if (!ok) chk("push_accept", 0, 1);
    endtask

    task automatic wait_op(input string tag);
        for (int k = 0; k < 100 && bus.v_alu_rst !== 1'b1; k++) step();
        chk(tag, bus.v_alu_rst, 1);
    endtask

    // steps 15 cycles of WAIT, flags any premature result
    task automatic hold_wait(input string tag);
        bit early = 1'b0;
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            step();
            if (bus.r_valid) early = 1'b1;
        end
        chk(tag, early, 0);
    endtask

    initial begin
        logic [VLEN-1:0] val;
        logic [31:0]     ops [5];
        logic [VLEN-1:0] rs [5];
        logic [31:0]     op_a;
        logic [31:0]     op_b;
        int              exp_ret;

        // ---------------- reset values
        idle_inputs();
        step();
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_v_instr", bus.v_instr, 0);
        chk("rst_alu_rst", bus.v_alu_rst, 0);
        chk("rst_r_valid", bus.r_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_retired", retired, 0);
        rst = 1'b1;
        step();
        exp_ret = 0;

        // ---------------- single op
        push(32'h0220_8057, 32'd8);
        chk("single_busy_queued", busy, 1);
        step();
        chk("single_issue_instr", bus.v_instr, 32'h0220_8057);
        chk("single_issue_vl", bus.v_vl, 8);
        chk("single_issue_alu_rst", bus.v_alu_rst, 0);
        step();
        chk("single_wait_alu_rst", bus.v_alu_rst, 1);
        step();
        step();
        bus.v_ready  = 1'b1;
        bus.v_result = 512'hA5;
        step();
        bus.v_ready = 1'b0;
        exp_ret++;
        chk("single_r_valid", bus.r_valid, 1);
        chk("single_r_data", bus.r_data, 512'hA5);
        chk("single_r_err", bus.r_err, 0);
        chk("single_retire_alu_rst", bus.v_alu_rst, 0);
        step();
        chk("single_retired", retired, exp_ret);
        chk("single_idle_busy", busy, 0);

        // ---------------- timeout
        push($urandom, $urandom);
        wait_op("tmo_enter_wait");
        hold_wait("tmo_no_early_result");
        step();
        exp_ret++;
        chk("tmo_r_valid", bus.r_valid, 1);
        chk("tmo_r_err", bus.r_err, 1);
        chk("tmo_r_data", bus.r_data, 0);
        chk("tmo_retire_alu_rst", bus.v_alu_rst, 0);
        step();

        // ---------------- v_ready on the last permitted cycle wins over timeout
        push($urandom, $urandom);
        wait_op("simul_enter_wait");
        hold_wait("simul_no_early_result");
        val = rnd_vec();
        bus.v_ready  = 1'b1;
        bus.v_result = val;
        step();
        bus.v_ready = 1'b0;
        exp_ret++;
        chk("simul_r_valid", bus.r_valid, 1);
        chk("simul_r_err", bus.r_err, 0);
        chk("simul_r_data", bus.r_data, val);
        step();

        // ---------------- result backpressure
        op_a = $urandom;
        op_b = $urandom;
        bus.r_ready = 1'b0;
        push(op_a, 32'd1);
        push(op_b, 32'd2);
        wait_op("bp_wait_a");
        val = rnd_vec();
        bus.v_ready  = 1'b1;
        bus.v_result = val;
        step();
        bus.v_ready = 1'b0;
        exp_ret++;
        for (int k = 0; k < 5; k++) step();
        chk("bp_held_instr", bus.v_instr, op_a);
        chk("bp_held_alu_rst", bus.v_alu_rst, 0);
        chk("bp_held_r_valid", bus.r_valid, 1);
        chk("bp_held_r_data", bus.r_data, val);
        chk("bp_held_busy", busy, 1);
        bus.r_ready = 1'b1;
        step();
        bus.r_ready = 1'b0;
        chk("bp_issue_b_instr", bus.v_instr, op_b);
        chk("bp_issue_b_r_valid", bus.r_valid, 0);
        chk("bp_issue_b_alu_rst", bus.v_alu_rst, 0);
        step();
        chk("bp_wait_b", bus.v_alu_rst, 1);
        val = rnd_vec();
        bus.v_ready  = 1'b1;
        bus.v_result = val;
        step();
        bus.v_ready = 1'b0;
        exp_ret++;
        chk("bp_b_r_data", bus.r_data, val);
        bus.r_ready = 1'b1;
        step();
        step();

        // ---------------- full FIFO with a stalled vector system
        for (int i = 0; i < 5; i++) begin
            ops[i] = $urandom;
            rs[i]  = rnd_vec();
            push(ops[i], i);
        end
        chk("full_s_ready", bus.s_ready, 0);
        for (int i = 0; i < 5; i++) begin
            wait_op("full_wait");
            chk("full_order_instr", bus.v_instr, ops[i]);
            step();
            bus.v_ready  = 1'b1;
            bus.v_result = rs[i];
            step();
            bus.v_ready = 1'b0;
            exp_ret++;
            chk("full_order_data", bus.r_data, rs[i]);
            chk("full_order_err", bus.r_err, 0);
        end
        step();
        step();
        chk("full_retired", retired, exp_ret);
        chk("full_drained_busy", busy, 0);

        // ---------------- randomized run against the queue model
        do_reset();
        begin
            issue_entry_t    iss_q [$];
            logic [VLEN-1:0] ed_q [$];
            bit              ee_q [$];
            int              n_req = 0;
            int              got = 0;
            int              lat = 0;
            int              wcnt = 0;
            bit              in_op = 1'b0;
            bit              push_hs;
            bit              pop_hs;
            issue_entry_t    e;

            for (int cyc = 0; cyc < 6000 && got < N_RAND; cyc++) begin
                if (bus.v_alu_rst) begin
                    if (!in_op) begin
                        in_op = 1'b1;
                        wcnt  = 0;
                        lat   = $urandom_range(0, 19);
                        if (iss_q.size() > 0) begin
                            e = iss_q.pop_front();
                            chk("rand_issue_instr", bus.v_instr, e.instr);
                            chk("rand_issue_vl", bus.v_vl, e.vl);
                        end else begin
                            chk("rand_issue_spurious", 1, 0);
                        end
                        if (lat >= TIMEOUT) begin
                            ed_q.push_back('0);
                            ee_q.push_back(1'b1);
                        end
                    end
                    if (lat < TIMEOUT && wcnt == lat) begin
                        bus.v_ready  = 1'b1;
                        bus.v_result = rnd_vec();
                        ed_q.push_back(bus.v_result);
                        ee_q.push_back(1'b0);
                    end else begin
                        bus.v_ready = 1'b0;
                    end
                end else begin
                    // outside WAIT v_ready is noise the controller must ignore
                    in_op        = 1'b0;
                    bus.v_ready  = 1'($urandom_range(0, 1));
                    bus.v_result = rnd_vec();
                end
                if (!bus.s_valid && n_req < N_RAND && $urandom_range(0, 2) == 0) begin
                    bus.s_valid = 1'b1;
                    bus.s_instr = $urandom;
                    bus.s_vl    = $urandom;
                    n_req++;
                end
                bus.r_ready = ($urandom_range(0, 3) != 0);
                push_hs = bus.s_valid && bus.s_ready;
                pop_hs  = bus.r_valid && bus.r_ready;
                if (pop_hs) begin
                    if (ed_q.size() > 0) begin
                        chk("rand_r_data", bus.r_data, ed_q.pop_front());
                        chk("rand_r_err", bus.r_err, ee_q.pop_front());
                    end else begin
                        chk("rand_r_spurious", 1, 0);
                    end
                    got++;
                end
                if (push_hs) iss_q.push_back('{instr: bus.s_instr, vl: bus.s_vl});
                step();
                wcnt++;
                if (push_hs) bus.s_valid = 1'b0;
            end
            chk("rand_all_results", got, N_RAND);
            bus.v_ready = 1'b0;
            step();
            step();
            step();
            chk("rand_retired", retired, N_RAND);
            chk("rand_idle_busy", busy, 0);
        end

        // ---------------- asynchronous reset mid-WAIT with two ops queued
        idle_inputs();
        push($urandom, $urandom);
        push($urandom, $urandom);
        push($urandom, $urandom);
        wait_op("arst_enter_wait");
        step();
        #2 rst = 1'b0;
        #1;
        chk("arst_alu_rst", bus.v_alu_rst, 0);
        chk("arst_v_instr", bus.v_instr, 0);
        chk("arst_v_vl", bus.v_vl, 0);
        chk("arst_busy", busy, 0);
        chk("arst_retired", retired, 0);
        chk("arst_s_ready", bus.s_ready, 1);
        chk("arst_r_data", bus.r_data, 0);
        step();
        rst = 1'b1;
        bus.v_ready = 1'b1;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                step();
                if (bus.r_valid || busy || bus.v_alu_rst) seen = 1'b1;
            end
            chk("arst_no_activity", seen, 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rvv_vector_issue_ctrl.md
Name: rvv_vector_issue_ctrl

Overview:
- Scalar-side issue controller; the initiator for the vector system's `instr`/`vl`/`ready` interface.
- Accepts vector instructions plus vl from the scalar pipeline over valid/ready and buffers them in a small FIFO.
- Presents one instruction at a time to the vector system and holds it stable until the system's `ready`.
- Sequences the ALU-only reset around each operation, captures the 512-bit result, and returns it to the scalar side over valid/ready.
- Flags timeouts.

Parameters:
- DEPTH, 4: instruction FIFO entries; power of two, ≥2.
- VLEN, 512: result width in bits.
- TIMEOUT, 1024: maximum WAIT cycles before the op is aborted.
- CNT_W, 16: width of the timeout counter and the retired-op counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- s_valid  in  1  scalar side presents an instruction.
- s_ready  out  1  FIFO can accept; equals !full.
- s_instr  in  32  vector instruction word.
- s_vl  in  32  vl for that instruction.
- v_instr  out  32  instruction driven to the vector system.
- v_vl  out  32  vl driven to the vector system.
- v_alu_rst  out  1  active-low ALU-only reset to the vector system.
- v_ready  in  1  completion from the vector system.
- v_result  in  VLEN  vreg_out from the vector system.
- r_valid  out  1  result available.
- r_ready  in  1  scalar side accepts the result.
- r_data  out  VLEN  captured result.
- r_err  out  1  result is a timeout abort; valid with r_valid.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- retired  out  CNT_W  count of retired ops; wraps.

Behaviour:
- Reset (rst low, asynchronous) clears the following:
  - FIFO pointers and count to 0; s_ready=1.
  - State to IDLE; v_instr=0; v_vl=0; v_alu_rst=0 (core held in reset).
  - r_valid=0, r_data=0, r_err=0, busy=0, retired=0, timeout counter=0.
- Reset mid-operation discards all queued and in-flight ops. No result is produced for them.
- FIFO push occurs when s_valid && s_ready. The entry is {s_instr, s_vl}. Pointers wrap modulo DEPTH.
- FIFO pop occurs only on the IDLE→ISSUE transition. Push and pop in the same cycle leave the count unchanged.
- No bypass: a push at cycle N is issuable at the earliest at N+1.
- FSM states:
  - IDLE: v_alu_rst=0.
    - If FIFO non-empty and the result slot is free (!r_valid, or r_ready this cycle), pop the head, register it into v_instr/v_vl, and go to ISSUE.
  - ISSUE: one cycle; v_alu_rst=0.
    - The decoder registers v_instr while the core is still held in reset.
    - Clear the timeout counter; go to WAIT.
  - WAIT: v_alu_rst=1; timeout counter increments every cycle.
    - If v_ready: r_data←v_result, r_err←0, r_valid←1, go to RETIRE.
    - Else if counter==TIMEOUT-1: r_data←0, r_err←1, r_valid←1, go to RETIRE.
    - v_ready on the same cycle as the timeout counts as success.
  - RETIRE: one cycle; v_alu_rst=0 to clear the core.
    - retired increments.
    - Go to IDLE.
- v_instr and v_vl change only on IDLE→ISSUE. They stay stable through ISSUE, WAIT and RETIRE.
- Minimum latency: pop at cycle N, then ISSUE at N+1 and WAIT from N+2. v_ready at cycle M gives r_valid at M+1. The next ISSUE is at M+3 at the earliest.
- r_valid stays high until r_ready. r_data and r_err are held stable while r_valid is high.
  - The next op is not popped while the result slot is occupied; there is a single result register.
- v_ready outside WAIT is ignored.
- busy = (state≠IDLE) || (count≠0).

Decomposition:
- The shared package (rvv_defs) gets:
  - an issue_state_t enum {IDLE, ISSUE, WAIT, RETIRE};
  - an issue_entry_t packed struct {instr[31:0], vl[31:0]}.
- Sub-module rvv_issue_fifo: parameterized DEPTH, entry type issue_entry_t, push/pop/full/empty/count.
- The top block holds the FSM, the timeout counter, the result register and the retire counter.

Test Plan:
- Single op:
  - Stimulus: push instr=32'h0220_8057 with vl=8; v_ready pulses 3 cycles after entering WAIT, with v_result=512'hA5.
  - Required: v_alu_rst low during ISSUE, high during WAIT; r_valid=1 one cycle later with r_data=512'hA5 and r_err=0; retired=1.
- Back-to-back and full FIFO:
  - Stimulus: push 5 ops with DEPTH=4 while the vector system stalls.
  - Required: s_ready=0 once 4 entries are held; results return in push order; retired=5 after all complete.
- Result backpressure:
  - Stimulus: hold r_ready=0 after the first result.
  - Required: the second op is not issued and v_instr stays at op 1. Once r_ready=1 for one cycle, op 2 is in ISSUE the next cycle.
- Timeout:
  - Stimulus: TIMEOUT=16, v_ready never asserted.
  - Required: r_valid with r_err=1 and r_data=0 exactly 16 cycles after entering WAIT; v_alu_rst low during RETIRE.
- Asynchronous reset mid-WAIT with 2 ops queued:
  - Required: outputs go to their reset values immediately without a clock edge; busy=0, retired=0.
  - Afterwards, no r_valid appears.
- Simultaneous v_ready and timeout:
  - Stimulus: v_ready asserted on the counter==TIMEOUT-1 cycle.
  - Required: r_err=0, and r_data equals v_result.
